// File: rtl/frogger_game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// frogger_game_ctrl_pkg
// Shared types and constants for the Frogger game-level sequencer:
// state encoding, field widths and the saturation limits for score and level.
// No ports.
// -----------------------------------------------------------------------------
package frogger_game_ctrl_pkg;

    localparam int ROW_W   = 6;
    localparam int LIVES_W = 2;
    localparam int LEVEL_W = 4;
    localparam int SCORE_W = 10;
    localparam int SPEED_W = 4;
    localparam int FRAME_W = 8;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 10'd1023;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DEATH     = 3'd2,
        ST_WIN       = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    // One extra bit holds the carry so the clamp needs a single compare.
    function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] a,
                                                     input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
        return (lvl == LEVEL_MAX) ? LEVEL_MAX : lvl + LEVEL_W'(1);
    endfunction

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// frogger_game_ctrl_if
// Bundle between the game sequencer and the rest of the game.
//   i_Frame_Tick  frame pulse          o_Frog_Reset  respawn pulse
//   i_Start       start pulse          o_Freeze      movers hold
//   i_Collided    collision flag       o_State       FSM state (HUD/debug)
//   i_Frogger_Y   frog row             o_Lives / o_Level / o_Score / o_Car_Speed
// Modports: slave = the sequencer, master = whatever drives the inputs.
// -----------------------------------------------------------------------------
interface frogger_game_ctrl_if;
    import frogger_game_ctrl_pkg::*;

    logic               i_Frame_Tick;
    logic               i_Start;
    logic               i_Collided;
    logic [ROW_W-1:0]   i_Frogger_Y;
    logic               o_Frog_Reset;
    logic               o_Freeze;
    logic [2:0]         o_State;
    logic [LIVES_W-1:0] o_Lives;
    logic [LEVEL_W-1:0] o_Level;
    logic [SCORE_W-1:0] o_Score;
    logic [SPEED_W-1:0] o_Car_Speed;

    modport slave (
        input  i_Frame_Tick, i_Start, i_Collided, i_Frogger_Y,
        output o_Frog_Reset, o_Freeze, o_State, o_Lives, o_Level, o_Score, o_Car_Speed
    );

    modport master (
        output i_Frame_Tick, i_Start, i_Collided, i_Frogger_Y,
        input  o_Frog_Reset, o_Freeze, o_State, o_Lives, o_Level, o_Score, o_Car_Speed
    );
endinterface

// File: rtl/frogger_game_ctrl_frame_timer.sv
// -----------------------------------------------------------------------------
// frogger_game_ctrl_frame_timer
// Loadable down-counter stepped by the frame tick, with a terminal-count flag.
//   i_Clk, i_Rst  clock, async active-high reset (count cleared)
//   i_Load        load i_Load_Val this cycle (wins over a tick)
//   i_Load_Val    frames to count
//   i_Tick        frame pulse; decrements while the count is nonzero
//   o_Done        high on the tick that takes the count from 1 to 0
// -----------------------------------------------------------------------------
module frogger_game_ctrl_frame_timer #(
    parameter int W = 8
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Load,
    input  logic [W-1:0] i_Load_Val,
    input  logic         i_Tick,
    output logic         o_Done
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_count <= '0;
        end else if (i_Load) begin
            r_count <= i_Load_Val;
        end else if (i_Tick && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_Done = i_Tick && !i_Load && (r_count == W'(1));

endmodule

// File: rtl/frogger_game_ctrl.sv
// -----------------------------------------------------------------------------
// frogger_game_ctrl
// Game-level sequencer: owns lives, level, score and the play/death/win/
// game-over flow; pulses frog respawn, freezes the movers during animations
// and derives car speed from the level.
// Ports:
//   i_Clk   system clock
//   i_Rst   asynchronous, active-high reset
//   io_Bus  frogger_game_ctrl_if.slave (frame tick, start, collision, frog Y in;
//           respawn, freeze, state, lives, level, score, car speed out)
// Build option:
//   FROGGER_INVULN_EN  after each respawn, collisions are ignored for
//                      INVULN_FRAMES frame ticks.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | after reset, movers frozen, waiting for start
// ST_PLAY      | frog live; collision > goal > row progress
// ST_DEATH     | death animation, DEATH_FRAMES ticks, then respawn/game over
// ST_WIN       | level-complete animation, WIN_FRAMES ticks, then respawn
// ST_GAME_OVER | no lives left, frozen, waiting for start
// -----------------------------------------------------------------------------
module frogger_game_ctrl
    import frogger_game_ctrl_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int GOAL_ROW     = 0,
    parameter int START_ROW    = 14,
    parameter int DEATH_FRAMES = 30,
    parameter int WIN_FRAMES   = 20,
    parameter int SCORE_STEP   = 1,
    parameter int SCORE_GOAL   = 50,
    parameter int BASE_SPEED   = 12
`ifdef FROGGER_INVULN_EN
    ,
    parameter int INVULN_FRAMES = 60
`endif
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    frogger_game_ctrl_if.slave   io_Bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LIVES_W-1:0]   r_lives,    w_lives_nxt;
    logic [LEVEL_W-1:0]   r_level,    w_level_nxt;
    logic [SCORE_W-1:0]   r_score,    w_score_nxt;
    logic [ROW_W-1:0]     r_best_row, w_best_row_nxt;
    logic                 r_frog_reset;
    logic                 r_freeze;
    logic [SPEED_W-1:0]   r_car_speed, w_car_speed;

    logic                 w_respawn;
    logic                 w_new_game;
    logic                 w_timer_load;
    logic [FRAME_W-1:0]   w_timer_val;
    logic                 w_timer_done;
    logic                 w_guard_active;

    // One timer serves both DEATH and WIN; it is reloaded on each entry.
    frogger_game_ctrl_frame_timer #(.W(FRAME_W)) u_anim_timer (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Load     (w_timer_load),
        .i_Load_Val (w_timer_val),
        .i_Tick     (io_Bus.i_Frame_Tick),
        .o_Done     (w_timer_done)
    );

`ifdef FROGGER_INVULN_EN
    logic               w_guard_done;
    logic               w_guard_load;
    logic [FRAME_W-1:0] w_guard_val;
    logic               r_guard_active;

    // A fresh game starts unguarded; only respawns from DEATH/WIN arm the guard.
    assign w_guard_load = w_respawn | w_new_game;
    assign w_guard_val  = w_respawn ? FRAME_W'(INVULN_FRAMES) : '0;

    frogger_game_ctrl_frame_timer #(.W(FRAME_W)) u_guard_timer (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Load     (w_guard_load),
        .i_Load_Val (w_guard_val),
        .i_Tick     (io_Bus.i_Frame_Tick),
        .o_Done     (w_guard_done)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_guard_active <= 1'b0;
        end else if (w_guard_load) begin
            r_guard_active <= (w_guard_val != '0);
        end else if (w_guard_done) begin
            r_guard_active <= 1'b0;
        end
    end

    assign w_guard_active = r_guard_active;
`else
    assign w_guard_active = 1'b0;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lives_nxt    = r_lives;
        w_level_nxt    = r_level;
        w_score_nxt    = r_score;
        w_best_row_nxt = r_best_row;
        w_respawn      = 1'b0;
        w_new_game     = 1'b0;
        w_timer_load   = 1'b0;
        w_timer_val    = '0;

        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (io_Bus.i_Start) begin
                    w_state_nxt    = ST_PLAY;
                    w_new_game     = 1'b1;
                    w_lives_nxt    = LIVES_W'(LIVES);
                    w_level_nxt    = '0;
                    w_score_nxt    = '0;
                    w_best_row_nxt = ROW_W'(START_ROW);
                end
            end
            ST_PLAY: begin
                if (io_Bus.i_Collided && !w_guard_active) begin
                    w_state_nxt  = ST_DEATH;
                    w_lives_nxt  = (r_lives == '0) ? '0 : r_lives - LIVES_W'(1);
                    w_timer_load = 1'b1;
                    w_timer_val  = FRAME_W'(DEATH_FRAMES);
                end else if (io_Bus.i_Frogger_Y == ROW_W'(GOAL_ROW)) begin
                    w_state_nxt  = ST_WIN;
                    w_score_nxt  = score_add(r_score, SCORE_W'(SCORE_GOAL));
                    w_level_nxt  = level_inc(r_level);
                    w_timer_load = 1'b1;
                    w_timer_val  = FRAME_W'(WIN_FRAMES);
                end else if (io_Bus.i_Frogger_Y < r_best_row) begin
                    w_best_row_nxt = io_Bus.i_Frogger_Y;
                    w_score_nxt    = score_add(r_score, SCORE_W'(SCORE_STEP));
                end
            end
            ST_DEATH, ST_WIN: begin
                if (w_timer_done) begin
                    if ((r_state == ST_DEATH) && (r_lives == '0)) begin
                        w_state_nxt = ST_GAME_OVER;
                    end else begin
                        w_state_nxt    = ST_PLAY;
                        w_respawn      = 1'b1;
                        w_best_row_nxt = ROW_W'(START_ROW);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Speed follows the registered level, so it trails a level change by a cycle.
    always_comb begin
        if (int'(r_level) >= BASE_SPEED - 1) begin
            w_car_speed = SPEED_W'(1);
        end else begin
            w_car_speed = SPEED_W'(BASE_SPEED - int'(r_level));
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_lives      <= '0;
            r_level      <= '0;
            r_score      <= '0;
            r_best_row   <= ROW_W'(START_ROW);
            r_frog_reset <= 1'b0;
            r_freeze     <= 1'b1;
            r_car_speed  <= SPEED_W'(BASE_SPEED);
        end else begin
            r_lives      <= w_lives_nxt;
            r_level      <= w_level_nxt;
            r_score      <= w_score_nxt;
            r_best_row   <= w_best_row_nxt;
            r_frog_reset <= w_respawn | w_new_game;
            r_freeze     <= (w_state_nxt != ST_PLAY);
            r_car_speed  <= w_car_speed;
        end
    end

    assign io_Bus.o_State      = r_state;
    assign io_Bus.o_Lives      = r_lives;
    assign io_Bus.o_Level      = r_level;
    assign io_Bus.o_Score      = r_score;
    assign io_Bus.o_Frog_Reset = r_frog_reset;
    assign io_Bus.o_Freeze     = r_freeze;
    assign io_Bus.o_Car_Speed  = r_car_speed;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
module tb_frogger_game_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_DEATH = 2;
    localparam int M_WIN   = 3;
    localparam int M_OVER  = 4;

    localparam int LIVES_0   = 3;
    localparam int START_ROW = 14;
    localparam int DEATH_T   = 30;
    localparam int WIN_T     = 20;
    localparam int BASE      = 12;
`ifdef FROGGER_INVULN_EN
    localparam int GUARD_T   = 60;
`else
    localparam int GUARD_T   = 0;
`endif

    typedef struct packed {
        int st;
        int fr;
        int fz;
        int lv;
        int lvl;
        int sc;
        int spd;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frogger_game_ctrl_if bus ();

    frogger_game_ctrl dut (
        .i_Clk  (clk),
        .i_Rst  (rst),
        .io_Bus (bus)
    );

    snap_t exp_q[$];
    snap_t mon_e, mon_a;
    int n_checks = 0;
    int n_pass   = 0;

    // Reference game model: plain integers, updated once per clock edge.
    int m_mode  = M_IDLE;
    int m_lives = 0;
    int m_level = 0;
    int m_score = 0;
    int m_best  = START_ROW;
    int m_anim  = 0;
    int m_guard = 0;
    int m_fr    = 0;
    int m_spd   = BASE;

    function automatic int clamp_score(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic model_step(input bit r, input bit tk, input bit st, input bit co, input int y);
        bit    anim_ends;
        bit    guarded;
        int    old_level;
        snap_t s;
        if (r) begin
            m_mode  = M_IDLE;
            m_lives = 0;
            m_level = 0;
            m_score = 0;
            m_best  = START_ROW;
            m_anim  = 0;
            m_guard = 0;
            m_fr    = 0;
            m_spd   = BASE;
        end else begin
            old_level = m_level;
            anim_ends = tk && (m_anim == 1);
            guarded   = (m_guard > 0);
            if (tk && m_anim > 0)  m_anim--;
            if (tk && m_guard > 0) m_guard--;
            m_fr = 0;
            case (m_mode)
                M_IDLE, M_OVER: begin
                    if (st) begin
                        m_mode  = M_PLAY;
                        m_lives = LIVES_0;
                        m_level = 0;
                        m_score = 0;
                        m_best  = START_ROW;
                        m_fr    = 1;
                        m_guard = 0;
                    end
                end
                M_PLAY: begin
                    if (co && !guarded) begin
                        m_mode  = M_DEATH;
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                        m_anim  = DEATH_T;
                    end else if (y == 0) begin
                        m_mode  = M_WIN;
                        m_score = clamp_score(m_score + 50);
                        m_level = (m_level < 15) ? m_level + 1 : 15;
                        m_anim  = WIN_T;
                    end else if (y < m_best) begin
                        m_best  = y;
                        m_score = clamp_score(m_score + 1);
                    end
                end
                default: begin
                    if (anim_ends) begin
                        if (m_mode == M_DEATH && m_lives == 0) begin
                            m_mode = M_OVER;
                        end else begin
                            m_mode  = M_PLAY;
                            m_fr    = 1;
                            m_best  = START_ROW;
                            m_guard = GUARD_T;
                        end
                    end
                end
            endcase
            m_spd = (BASE - old_level < 1) ? 1 : BASE - old_level;
        end
        s.st  = m_mode;
        s.fr  = m_fr;
        s.fz  = (m_mode == M_PLAY) ? 0 : 1;
        s.lv  = m_lives;
        s.lvl = m_level;
        s.sc  = m_score;
        s.spd = m_spd;
        exp_q.push_back(s);
    endtask

    task automatic step(input bit r, input bit tk, input bit st, input bit co, input int y);
        @(negedge clk);
        rst              = r;
        bus.i_Frame_Tick = tk;
        bus.i_Start      = st;
        bus.i_Collided   = co;
        bus.i_Frogger_Y  = 6'(y);
        model_step(r, tk, st, co, y);
    endtask

    // Monitor: every edge the DUT presents a fresh output set; compare it.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e     = exp_q.pop_front();
            mon_a.st  = int'(bus.o_State);
            mon_a.fr  = int'(bus.o_Frog_Reset);
            mon_a.fz  = int'(bus.o_Freeze);
            mon_a.lv  = int'(bus.o_Lives);
            mon_a.lvl = int'(bus.o_Level);
            mon_a.sc  = int'(bus.o_Score);
            mon_a.spd = int'(bus.o_Car_Speed);
            n_checks++;
            if (mon_a == mon_e) begin
                n_pass++;
            end else begin
                $display("FAIL outputs t=%0t actual st=%0d rst=%0d frz=%0d lives=%0d lvl=%0d score=%0d spd=%0d required st=%0d rst=%0d frz=%0d lives=%0d lvl=%0d score=%0d spd=%0d",
                         $time, mon_a.st, mon_a.fr, mon_a.fz, mon_a.lv, mon_a.lvl, mon_a.sc, mon_a.spd,
                         mon_e.st, mon_e.fr, mon_e.fz, mon_e.lv, mon_e.lvl, mon_e.sc, mon_e.spd);
            end
        end
    end

    initial begin
        int y;
        bus.i_Frame_Tick = 1'b0;
        bus.i_Start      = 1'b0;
        bus.i_Collided   = 1'b0;
        bus.i_Frogger_Y  = 6'd14;

        // Reset with garbage inputs, then IDLE ignores everything but start.
        repeat (3) step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, int'($urandom_range(0, 63)));
        repeat (3) step(0, 1, 0, 1, 0);

        // Start, row progress 14->13->12->12, off-path row, then collision.
        step(0, 0, 1, 0, 14);
        step(0, 0, 0, 0, 14);
        step(0, 0, 0, 0, 13);
        step(0, 1, 0, 0, 12);
        step(0, 0, 0, 0, 12);
        step(0, 0, 0, 0, 20);
        step(0, 0, 0, 1, 12);
        repeat (40) step(0, 1, 0, 0, 14);
        step(0, 0, 0, 1, 14);
        repeat (51) step(0, 1, 0, 0, 14);
        step(0, 0, 0, 1, 14);

        // Run the game down to GAME_OVER.
        for (int k = 0; k < 8 && m_mode != M_OVER; k++) begin
            step(0, 0, 0, 1, 14);
            repeat (95) step(0, 1, 0, 0, 14);
        end

        // Restart; goal and collision together, then a clean goal.
        step(0, 0, 1, 0, 14);
        step(0, 0, 0, 1, 0);
        repeat (32) step(0, 1, 0, 0, 14);
        repeat (62) step(0, 1, 0, 0, 14);
        step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 5);
        repeat (22) step(0, 1, 0, 0, 14);

        // Reset in the middle of a death animation.
        repeat (62) step(0, 1, 0, 0, 14);
        step(0, 0, 0, 1, 14);
        repeat (5) step(0, 1, 0, 0, 14);
        repeat (2) step(1, 1, 1, 1, 3);
        repeat (2) step(0, 0, 0, 0, 14);

        // Score and level saturation through repeated goals.
        step(0, 0, 1, 0, 14);
        for (int k = 0; k < 22; k++) begin
            step(0, 0, 0, 0, 0);
            repeat (21) step(0, 1, 0, 0, 14);
        end
        repeat (3) step(0, 0, 0, 0, 14);

        // Randomized play.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 1) == 1)
                y = (m_best > 0) ? m_best - 1 : 0;
            else
                y = int'($urandom_range(0, 20));
            step(($urandom_range(0, 699) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 59) == 0),
                 y);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
